// File: rtl/lfsr_sched_pkg.sv
// Shared types and constants for the LFSR scheduler slice.
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  // Power-on state and the substitute for an all-zero seed.
  localparam int unsigned SEED = 1;

  // Maximal-length feedback masks for the shift-left form {q[W-2:0], ^(q & taps)}.
  function automatic logic [31:0] default_taps(input int w);
    case (w)
      2:       return 32'b11;
      3:       return 32'b110;
      4:       return 32'b1100;
      5:       return 32'b10100;
      6:       return 32'b110000;
      7:       return 32'b1100000;
      8:       return 32'b10111000;
      default: return 32'b110;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_sched_if.sv
// Request/result bundle between the LFSR scheduler and its requesters.
interface lfsr_sched_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
);
  logic [1:0]       req;
  logic [CNT_W-1:0] req_steps0;
  logic [CNT_W-1:0] req_steps1;
  logic             seed_we;
  logic [WIDTH-1:0] seed_val;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rnd;
  logic [WIDTH-1:0] lfsr_q;

  modport master (
    output req, req_steps0, req_steps1, seed_we, seed_val,
    input  gnt, busy, done, rnd, lfsr_q
  );

  modport slave (
    input  req, req_steps0, req_steps1, seed_we, seed_val,
    output gnt, busy, done, rnd, lfsr_q
  );
endinterface

// File: rtl/lfsr_sched_core.sv
// Fibonacci-style LFSR with load; an all-zero load is replaced by SEED.
module lfsr_core import lfsr_pkg::*; #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(SEED);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)        q <= RST_Q;
    else if (ld)       q <= (d == '0) ? RST_Q : d;
    else if (en)       q <= {q[WIDTH-2:0], ^(q & TAPS)};
  end
endmodule

// File: rtl/lfsr_sched.sv
// Two-way round-robin front end that lends the shared LFSR to one requester
// for a fixed number of steps and returns the resulting state.
module lfsr_sched import lfsr_pkg::*; #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter int               CNT_W = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  lfsr_sched_if.slave bus
);
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   last_q, last_d;  // last-served requester, also the current owner
  logic                   win;
  logic [1:0][CNT_W-1:0]  steps;
  logic [WIDTH-1:0]       rnd_q;
  logic [WIDTH-1:0]       q;
  logic                   core_en, core_ld;

  assign steps = {bus.req_steps1, bus.req_steps0};

  // On a tie the requester not served last wins.
  assign win = (bus.req == 2'b11) ? ~last_q : bus.req[1];

  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (core_en),
    .ld    (core_ld),
    .d     (bus.seed_val),
    .q     (q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    core_en = 1'b0;
    core_ld = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.seed_we) begin
          core_ld = 1'b1;
        end else if (|bus.req) begin
          last_d  = win;
          cnt_d   = steps[win];
          state_d = (steps[win] != '0) ? STEP : DONE;
        end
      end
      STEP: begin
        core_en = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      if (state_q == DONE) rnd_q <= q;
    end
  end

  // q is frozen during DONE, so the result is presented directly and then held.
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.gnt    = bus.busy ? (last_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rnd    = bus.done ? q : rnd_q;
  assign bus.lfsr_q = q;
endmodule

// File: doc/lfsr_sched.md
# lfsr_sched

Round-robin scheduler that shares a single pseudo-random generator between two requesters. Each requester asks for a fixed number of LFSR advance steps. The block grants one requester at a time, clocks the generator for exactly that many cycles, then returns the resulting state with a one-cycle done pulse. It sits between the 3-bit LFSR datapath and its consumers, and also owns seed loading.

## Interface
- WIDTH, 3: LFSR state width (≥2).
- TAPS, 3'b110: feedback tap mask, width WIDTH. Default is x^3+x^2+1, maximal length, period 7.
- CNT_W, 4: width of step-count fields.
- CLK  in  1: sole clock, rising edge.
- RESET  in  1: asynchronous, active-low reset.
- req  in  2: request per requester; level, held until own done.
- req_steps0 / req_steps1  in  CNT_W each: step count for requester 0 / 1, sampled with grant.
- seed_we  in  1: seed load strobe, honoured only in IDLE.
- seed_val  in  WIDTH: seed value.
- gnt  out  2: one-hot grant or 0.
- busy  out  1: high when FSM is not IDLE.
- done  out  1: one-cycle pulse, result valid.
- rnd  out  WIDTH: result; valid when done=1, holds value otherwise.
- lfsr_q  out  WIDTH: live generator state.

## Operation
- LFSR step: next = {q[WIDTH-2:0], ^(q & TAPS)}. From 001 the sequence is 001,010,101,011,111,110,100,001.
- FSM states: IDLE, STEP, DONE.
  - IDLE: if seed_we, load seed_val, or 1 if seed_val==0 (all-zero lock-up forbidden); requests wait. Seed has priority over requests in the same cycle.
  - IDLE with any req and no seed_we: pick winner, latch id and steps, set gnt. Go to STEP if steps≠0, else DONE.
  - STEP: advance LFSR, decrement counter. When counter==1 on this edge, go to DONE.
  - DONE: done=1, rnd=q, gnt held. Next edge goes to IDLE and clears gnt.
- Arbitration: if only one requester is asserted, it wins. If both, the one not granted last wins. The last-served pointer updates on grant.
- req deassert during STEP/DONE: ignored; transaction completes.
- seed_we outside IDLE: dropped, not queued.
- Counter is CNT_W bits and unsigned. Steps range 0..2^CNT_W-1. No wrap: transaction ends at terminal count.
- Reset values: q=1, FSM=IDLE, gnt=0, busy=0, done=0, rnd=0, last-served pointer=requester 1 (so requester 0 wins the first tie).
- RESET asserted mid-transaction: immediate return to reset values; transaction discarded, no done.

## Timing
- Request sampled at edge E0. gnt and busy go high after E0.
- N≥1: LFSR advances on edges E1..EN. done is high in the cycle after EN. gnt and busy drop after EN+1.
- N=0: done is high in the cycle after E0; LFSR is not advanced.
- Result = initial state advanced N times.
- Back-to-back: the earliest next grant is sampled at EN+2, since one IDLE cycle is mandatory.
- Seed load: lfsr_q shows the new value one cycle after the seed_we edge.

## Structure
- Shared package lfsr_pkg holds:
  - FSM state enum {IDLE, STEP, DONE}.
  - Default TAPS per width (3: 3'b110).
  - Reset seed constant (1).
- Sub-module lfsr_core (WIDTH, TAPS): ports CLK, RESET, en, ld, d, q. Handles the zero-seed substitution internally.
- lfsr_sched contains the FSM, arbiter pointer and step counter.

## Test plan
- Reset release, req=01, steps0=3 -> gnt=01 after E0; done after E3 with rnd=011; lfsr_q=011.
- From 001, req=10, steps1=7 -> rnd=001 (full period). Then steps1=0 -> done after E0, rnd=001, no advance.
- req=11 held continuously -> grants alternate 01,10,01,10. Each done is followed by one IDLE cycle before the next gnt.
- seed_we with seed_val=000 in IDLE -> lfsr_q=001. seed_we with 110 while busy -> ignored. seed_we and req in the same IDLE cycle -> seed loaded, grant one cycle later.
- RESET pulsed low during STEP with steps=5 -> outputs at reset values immediately, no done, lfsr_q=001. Next request proceeds from 001.
- Requester drops req mid-STEP -> transaction still completes with correct rnd and done.
